// File: rtl/max_stream_pkg.sv
// Shared FSM state encoding and compare-mode constants for the max_stream frame reducer.
package max_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/max_stream_cmp.sv
// Strict replace decision: take_b when b beats a (greater for max, less for min); ties keep a.
module max_stream_cmp
  import max_stream_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             take_b
);

  logic gt;
  logic lt;

  generate
    if (SIGNED) begin : g_signed
      assign gt = $signed(b) > $signed(a);
      assign lt = $signed(b) < $signed(a);
    end else begin : g_unsigned
      assign gt = b > a;
      assign lt = b < a;
    end
  endgenerate

  assign take_b = (mode == MODE_MIN) ? lt : gt;

endmodule

// File: rtl/max_stream.sv
// Per-frame max/min reducer: result 1 cycle after the closing element, held until out_ready (one bubble per frame).
// Optional out_index output (position of reported element) when MAX_STREAM_INDEX_EN is defined.
module max_stream
  import max_stream_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_LEN = 16,
  parameter bit SIGNED  = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_value,
  output logic [$clog2(MAX_LEN+1)-1:0] out_count,
  output logic                         out_trunc
`ifdef MAX_STREAM_INDEX_EN
  ,
  output logic [$clog2(MAX_LEN)-1:0]   out_index
`endif
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);

  state_t state;
  logic   mode_q;
  logic   take_b;

  // The result registers double as the running accumulator while the frame is open.
  max_stream_cmp #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_cmp (
    .a     (out_value),
    .b     (in_data),
    .mode  (mode_q),
    .take_b(take_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_value <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
      mode_q    <= MODE_MAX;
`ifdef MAX_STREAM_INDEX_EN
      out_index <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_value <= in_data;
            out_count <= CW'(1);
            out_trunc <= 1'b0;
            mode_q    <= mode;
`ifdef MAX_STREAM_INDEX_EN
            out_index <= '0;
`endif
            if (in_last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            if (take_b) begin
              out_value <= in_data;
`ifdef MAX_STREAM_INDEX_EN
              out_index <= out_count[IW-1:0];
`endif
            end
            out_count <= out_count + CW'(1);
            // Reaching MAX_LEN without in_last force-closes the frame.
            if (in_last || out_count == LAST_CNT) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_trunc <= ~in_last;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_stream.sv
// Scoreboard bench: unsigned and signed instances share one stream; a frame-level model predicts each result.
module tb_max_stream;

  localparam int W = 4;
  localparam int L = 4;

  typedef struct {
    int value;
    int count;
    int trunc;
    int index;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, mode, in_valid, in_last, out_ready;
  logic [3:0] in_data;
  logic       rdy0, rdy1, ov0, ov1, tr0, tr1;
  logic [3:0] val0, val1;
  logic [2:0] cnt0, cnt1;
`ifdef MAX_STREAM_INDEX_EN
  logic [1:0] idx0, idx1;
`endif

  exp_t       q0[$];
  exp_t       q1[$];
  logic [3:0] frame[$];
  bit         fmode;
  bit         rdy_en = 1'b1;
  int         checks = 0;
  int         failures = 0;

  max_stream #(.WIDTH(W), .MAX_LEN(L), .SIGNED(1'b0)) dut0 (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
    .out_value(val0), .out_count(cnt0), .out_trunc(tr0)
`ifdef MAX_STREAM_INDEX_EN
    , .out_index(idx0)
`endif
  );

  max_stream #(.WIDTH(W), .MAX_LEN(L), .SIGNED(1'b1)) dut1 (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
    .out_value(val1), .out_count(cnt1), .out_trunc(tr1)
`ifdef MAX_STREAM_INDEX_EN
    , .out_index(idx1)
`endif
  );

  initial forever #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic int key(logic [3:0] v, bit s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  // Extreme over the whole frame, then the earliest element holding that extreme.
  function automatic void close_frame(bit tr);
    for (int s = 0; s < 2; s++) begin
      exp_t e;
      int   best = key(frame[0], s[0]);
      int   idx  = -1;
      foreach (frame[i]) begin
        if (fmode ? key(frame[i], s[0]) < best : key(frame[i], s[0]) > best)
          best = key(frame[i], s[0]);
      end
      foreach (frame[i]) if (idx < 0 && key(frame[i], s[0]) == best) idx = i;
      e.value = int'(frame[idx]);
      e.count = frame.size();
      e.trunc = int'(tr);
      e.index = idx;
      if (s == 0) q0.push_back(e); else q1.push_back(e);
    end
    frame.delete();
  endfunction

  function automatic void model_accept(logic [3:0] d, bit l, bit m);
    if (frame.size() == 0) fmode = m;
    frame.push_back(d);
    if (l) close_frame(1'b0);
    else if (frame.size() == L) close_frame(1'b1);
  endfunction

  task automatic send(logic [3:0] d, bit l, bit m);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; mode = m;
    while (!rdy0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 0, 1);
    else model_accept(d, l, m);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) chk("drain_timeout", q0.size() + q1.size(), 0);
  endtask

  task automatic score(int which, logic [3:0] v, logic [2:0] c, logic t, int ix);
    exp_t e;
    if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
      chk($sformatf("unexpected_result_dut%0d", which), int'(v), -1);
    end else begin
      e = (which == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("value_dut%0d", which), int'(v), e.value);
      chk($sformatf("count_dut%0d", which), int'(c), e.count);
      chk($sformatf("trunc_dut%0d", which), int'(t), e.trunc);
`ifdef MAX_STREAM_INDEX_EN
      chk($sformatf("index_dut%0d", which), ix, e.index);
`endif
    end
  endtask

  // Monitor: a result is consumed at the next rising edge when valid and ready both show here.
  initial forever begin
    @(negedge clk);
    if (!reset && out_ready) begin
`ifdef MAX_STREAM_INDEX_EN
      if (ov0) score(0, val0, cnt0, tr0, int'(idx0));
      if (ov1) score(1, val1, cnt1, tr1, int'(idx1));
`else
      if (ov0) score(0, val0, cnt0, tr0, 0);
      if (ov1) score(1, val1, cnt1, tr1, 0);
`endif
    end
  end

  initial forever begin
    @(posedge clk);
    #1 if (rdy_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] hold_v;
    logic [2:0] hold_c;
    reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", int'(ov0), 0);
    chk("reset_in_ready", int'(rdy0), 1);
    chk("reset_value", int'(val0), 0);
    chk("reset_count", int'(cnt0), 0);
    chk("reset_trunc", int'(tr1), 0);

    // Unsigned max 3,9,2,9 and signed min 3,E,7.
    send(4'd3, 0, 0); send(4'd9, 0, 0); send(4'd2, 0, 0); send(4'd9, 1, 0);
    send(4'h3, 0, 1); send(4'hE, 0, 1); send(4'h7, 1, 1);
    // Force-close at MAX_LEN, then a single-element frame.
    send(4'd5, 0, 0); send(4'd6, 0, 0); send(4'd7, 0, 0); send(4'd8, 0, 0);
    send(4'd1, 1, 0);
    // Mode toggled mid-frame is ignored.
    send(4'd2, 0, 0); send(4'd7, 0, 1); send(4'd1, 1, 1);

    // Consumer stall: result must hold and input must stay blocked.
    wait_drain();
    @(posedge clk);
    #1 rdy_en = 1'b0; out_ready = 1'b0;
    send(4'd6, 1, 0);
    @(negedge clk);
    chk("stall_first_valid", int'(ov0), 1);
    hold_v = val0; hold_c = cnt0;
    chk("stall_held_value", int'(hold_v), 6);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 4'hF; in_last = 1'b1;
      @(negedge clk);
      chk("stall_valid", int'(ov0), 1);
      chk("stall_value", int'(val0), int'(hold_v));
      chk("stall_count", int'(cnt0), int'(hold_c));
      chk("stall_in_ready", int'(rdy0), 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 rdy_en = 1'b1; out_ready = 1'b1;

    // Reset mid-frame alongside an offered element.
    wait_drain();
    send(4'd3, 0, 0); send(4'd8, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'd5; in_last = 1'b0; reset = 1'b1;
    frame.delete();
    @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", int'(ov0), 0);
    chk("midreset_in_ready", int'(rdy0), 1);
    chk("midreset_count", int'(cnt0), 0);
    chk("midreset_value", int'(val1), 0);
    send(4'd4, 1, 0);

    // Randomized frames, including over-length ones and mid-frame mode flips.
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 6);
      bit m   = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        bit mm = ($urandom_range(0, 3) == 0) ? ~m : m;
        send(4'($urandom_range(0, 15)), (i == len - 1), mm);
      end
    end

    wait_drain();
    repeat (4) @(negedge clk);
    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_stream.md
MAX_STREAM -- requirements
Module: max_stream

Interface
REQ-001 Parameter WIDTH, default 4, element width in bits.
REQ-002 Parameter MAX_LEN, default 16, maximum elements per frame (>=2).
REQ-003 Parameter SIGNED, default 0; 1 = two's-complement compare, 0 = unsigned.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports named as below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 mode  in  1  0 = track maximum, 1 = track minimum; sampled on a frame's first accepted element.
REQ-008 in_valid  in  1  input element valid.
REQ-009 in_ready  out  1  block accepts element when in_valid & in_ready.
REQ-010 in_data  in  WIDTH  element value.
REQ-011 in_last  in  1  final element of frame.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  consumer accepts result when out_valid & out_ready.
REQ-014 out_value  out  WIDTH  extreme value of frame.
REQ-015 out_count  out  $clog2(MAX_LEN+1)  elements in frame.
REQ-016 out_trunc  out  1  frame force-closed at MAX_LEN without in_last.

Function
REQ-017 FSM states IDLE, ACCUM, HOLD; in_ready SHALL be 1 in IDLE/ACCUM, 0 in HOLD.
REQ-018 IDLE: accepted element loads value register, count=1, latches mode; -> ACCUM, or -> HOLD if in_last.
REQ-019 ACCUM: accepted element replaces stored value only if strictly greater (max) / strictly less (min); ties keep earlier element; count increments.
REQ-020 Accepted element with in_last in ACCUM -> HOLD, out_trunc=0.
REQ-021 Accepted element making count==MAX_LEN without in_last -> HOLD, out_trunc=1; next element starts new frame.
REQ-022 out_valid SHALL be 1 exactly while in HOLD; result appears the cycle after the closing element is accepted (latency 1).
REQ-023 Outputs SHALL stay stable in HOLD until out_ready; on handshake -> IDLE, in_ready=1 next cycle (one bubble per frame).
REQ-024 Single-element frame (first element with in_last) SHALL give out_value=that element, out_count=1.
REQ-025 Changes on mode mid-frame SHALL be ignored until the next frame.
REQ-026 Compare SHALL use SIGNED parameter; no arithmetic overflow possible (comparison only).

Reset
REQ-027 Reset SHALL force IDLE, out_valid=0, out_value=0, out_count=0, out_trunc=0, out_index=0, discarding any partial frame or held result.
REQ-028 Reset SHALL take priority over every simultaneous handshake.

Configuration
REQ-029 Macro MAX_STREAM_INDEX_EN defined: extra output out_index [$clog2(MAX_LEN)-1:0] = zero-based position of the reported element (earliest on ties), valid with out_valid.
REQ-030 Macro undefined: out_index port and its register SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package max_stream_pkg SHALL hold FSM state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2) and mode constants MODE_MAX=1'b0, MODE_MIN=1'b1.
REQ-032 Combinational sub-module max_stream_cmp (a, b, mode, signed param -> take_b) SHALL implement the strict replace decision.

Verification (WIDTH=4, MAX_LEN=4 unless stated)
REQ-033 mode=0, unsigned, frame 3,9,2,9(last) -> out_value=9, out_count=4, out_index=1, out_trunc=0.
REQ-034 mode=1, SIGNED=1, frame 4'h3,4'hE,4'h7(last) -> out_value=4'hE (-2), out_count=3, out_index=1.
REQ-035 Frame 5,6,7,8 no in_last -> out_value=8, out_count=4, out_trunc=1; next element 1(last) -> separate frame, out_value=1, count=1.
REQ-036 out_ready held 0 for 5 cycles after result -> out_valid stays 1, outputs unchanged, in_ready=0, in_valid elements not accepted.
REQ-037 Reset asserted in ACCUM after 2 elements, same cycle as in_valid -> next cycle IDLE, out_valid=0, new frame 4(last) reports count=1.
REQ-038 Mode toggled 0->1 mid-frame 2,7,1(last) -> out_value=7 (max retained).
